// File: rtl/instruction_fetch.sv
// Generic flushable FIFO holding fetched words between memory return and decode.
// Latency: push visible at head the cycle after the write edge; pop removes head at edge.
// Backpressure: none internally; the producer must not push when full (credit-limited upstream).
module fifo #(
    parameter int W     = 42,
    parameter int DEPTH = 2
) (
    input  logic                     CLK_SYS,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_rdy,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge CLK_SYS or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_rdy) rd_ptr <= rd_ptr + 1'b1;
            case ({push_vld, pop_rdy})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge CLK_SYS) disable iff (!rst_n)
        !(push_vld && !pop_rdy && !flush && count == (AW+1)'(DEPTH)));
    a_count_bound: assert property (@(posedge CLK_SYS) disable iff (!rst_n)
        count <= (AW+1)'(DEPTH));
endmodule

// Instruction fetch: issues word addresses to a 1-cycle registered memory, queues returns for decode.
// Latency: address presented in cycle t -> if_valid with that word in t+2; redirect target valid 3 cycles later.
// Backpressure: id_ready low holds head; issue stops once queued + in-flight words reach QDEPTH.
module instruction_fetch #(
    parameter logic [9:0] RESET_PC = 10'd0,
    parameter int         QDEPTH   = 2
) (
    input  logic        CLK_SYS,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        branch_taken,
    input  logic [9:0]  branch_target,
    output logic [9:0]  pc,
    input  logic [31:0] instruction,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [9:0]  if_pc,
    input  logic        id_ready
);
    localparam int CW = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [9:0]  pc;
    } fetch_ent_t;

    logic [9:0]    pc_q;
    logic [9:0]    ipc_q;
    logic          inflight;
    logic [CW-1:0] q_count;
    logic [CW:0]   occ;
    logic          pop_rdy;
    logic          push_vld;
    logic          issue_vld;
    fetch_ent_t    push_dat;
    fetch_ent_t    head_dat;

    // Occupancy counts the in-flight word so a push can never land on a full queue.
    always_comb begin
        pop_rdy   = if_valid && id_ready && !branch_taken;
        push_vld  = inflight && !branch_taken;
        occ       = {1'b0, q_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop_rdy};
        issue_vld = fetch_en && !branch_taken && (occ < (CW+1)'(QDEPTH));
        push_dat  = '{instr: instruction, pc: ipc_q};
    end

    always_ff @(posedge CLK_SYS or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            ipc_q    <= '0;
            inflight <= 1'b0;
        end else if (branch_taken) begin
            pc_q     <= branch_target;
            inflight <= 1'b0;
        end else if (issue_vld) begin
            inflight <= 1'b1;
            ipc_q    <= pc_q;
            pc_q     <= pc_q + 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    fifo #(
        .W     ($bits(fetch_ent_t)),
        .DEPTH (QDEPTH)
    ) u_queue (
        .CLK_SYS  (CLK_SYS),
        .rst_n    (rst_n),
        .flush    (branch_taken),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (pop_rdy),
        .head_dat (head_dat),
        .count    (q_count)
    );

    assign pc       = pc_q;
    assign if_valid = (q_count != '0);
    assign if_instr = head_dat.instr;
    assign if_pc    = head_dat.pc;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: registered memory model plus an in-order scoreboard of expected fetch addresses.
module tb_instruction_fetch;
    logic        CLK_SYS;
    logic        rst_n;
    logic        fetch_en;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic [9:0]  pc;
    logic [31:0] instruction;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [9:0]  if_pc;
    logic        id_ready;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [9:0]  exp_q [$];
    logic [9:0]  sb_pc;

    instruction_fetch #(.RESET_PC(10'd0), .QDEPTH(2)) dut (
        .CLK_SYS       (CLK_SYS),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .instruction   (instruction),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .id_ready      (id_ready)
    );

    initial CLK_SYS = 1'b0;
    always #5 CLK_SYS = ~CLK_SYS;

    function automatic logic [31:0] memval(input logic [9:0] a);
        return {a, 12'hABC, a};
    endfunction

    // Instruction memory: registered read of the presented address.
    always @(posedge CLK_SYS) instruction <= memval(pc);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK_SYS);
        #1;
    endtask

    task automatic push_run(input logic [9:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 10'(i));
    endtask

    // Every accepted word is scored against the next expected address.
    always @(negedge CLK_SYS) begin
        if (rst_n && if_valid && id_ready && !branch_taken) begin
            check("sb_have", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                sb_pc = exp_q.pop_front();
                check("sb_pc", 32'(if_pc), 32'(sb_pc));
                check("sb_instr", if_instr, memval(sb_pc));
            end
        end
    end

    task automatic release_and_check;
        tick;
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        id_ready = 1'b1;
        @(negedge CLK_SYS);
        check("c0_pc", 32'(pc), 32'd0);
        check("c0_valid", 32'(if_valid), 32'd0);
        tick;
        @(negedge CLK_SYS);
        check("c1_pc", 32'(pc), 32'd1);
        check("c1_valid", 32'(if_valid), 32'd0);
        tick;
        @(negedge CLK_SYS);
        check("c2_valid", 32'(if_valid), 32'd1);
        check("c2_if_pc", 32'(if_pc), 32'd0);
        check("c2_if_instr", if_instr, memval(10'd0));
    endtask

    task automatic drain(input int budget, input bit toggle);
        int n;
        n = 0;
        tick;
        id_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick;
            n++;
            if (toggle) fetch_en = ~fetch_en;
        end
        id_ready = 1'b0;
        fetch_en = 1'b1;
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        fetch_en      = 1'b1;
        id_ready      = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 10'd0;

        @(negedge CLK_SYS);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", 32'(if_pc), 32'd0);
        check("rst_if_instr", if_instr, 32'd0);

        // Startup stream, then a 5-cycle stall with head at address 3.
        push_run(10'd0, 7);
        release_and_check();
        for (int c = 3; c < 5; c++) begin
            tick;
            @(negedge CLK_SYS);
            check("stream_valid", 32'(if_valid), 32'd1);
        end
        tick;
        id_ready = 1'b0;
        @(negedge CLK_SYS);
        check("stall_if_pc", 32'(if_pc), 32'd3);
        check("stall_pc", 32'(pc), 32'd5);
        for (int c = 6; c < 10; c++) begin
            tick;
            @(negedge CLK_SYS);
            check("stall_hold_valid", 32'(if_valid), 32'd1);
            check("stall_hold_pc", 32'(if_pc), 32'd3);
            check("stall_hold_instr", if_instr, memval(10'd3));
            check("stall_pc_frozen", 32'(pc), 32'd5);
        end
        drain(20, 1'b0);

        // Redirect with a full queue and decode stalled.
        repeat (4) tick;
        @(negedge CLK_SYS);
        check("full_valid", 32'(if_valid), 32'd1);
        tick;
        branch_taken  = 1'b1;
        branch_target = 10'd20;
        push_run(10'd20, 3);
        tick;
        branch_taken = 1'b0;
        @(negedge CLK_SYS);
        check("redir_valid0", 32'(if_valid), 32'd0);
        check("redir_pc", 32'(pc), 32'd20);
        tick;
        @(negedge CLK_SYS);
        check("redir_valid1", 32'(if_valid), 32'd0);
        tick;
        @(negedge CLK_SYS);
        check("redir_valid2", 32'(if_valid), 32'd1);
        check("redir_if_pc", 32'(if_pc), 32'd20);
        check("redir_if_instr", if_instr, memval(10'd20));
        drain(20, 1'b0);

        // Address wrap through 1023.
        branch_taken  = 1'b1;
        branch_target = 10'd1022;
        push_run(10'd1022, 4);
        tick;
        branch_taken = 1'b0;
        @(negedge CLK_SYS);
        check("wrap_pc", 32'(pc), 32'd1022);
        drain(30, 1'b0);

        // fetch_en toggling every cycle.
        branch_taken  = 1'b1;
        branch_target = 10'd100;
        push_run(10'd100, 12);
        tick;
        branch_taken = 1'b0;
        drain(80, 1'b1);

        // Asynchronous reset while stalled with a full queue.
        repeat (4) tick;
        @(negedge CLK_SYS);
        check("pre_rst_valid", 32'(if_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(if_valid), 32'd0);
        check("async_rst_pc", 32'(pc), 32'd0);
        check("async_rst_if_pc", 32'(if_pc), 32'd0);
        check("async_rst_instr", if_instr, 32'd0);
        exp_q.delete();
        repeat (2) tick;
        push_run(10'd0, 6);
        release_and_check();
        drain(20, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
